// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Inserts bubbles on flush or load-use hazard, and counts hazard bubbles with a saturating counter.
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_in,
    input  logic                  stall_in,
    input  logic                  valid_id,
    input  logic [DATA_W-1:0]     read_data_1_id,
    input  logic [DATA_W-1:0]     read_data_2_id,
    input  logic [DATA_W-1:0]     sign_extended_id,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  mem_read_id,
    input  logic [CTRL_W-1:0]     ctrl_id,
    output logic [DATA_W-1:0]     read_data_1_ex,
    output logic [DATA_W-1:0]     read_data_2_ex,
    output logic [DATA_W-1:0]     sign_extended_ex,
    output logic [REG_ADDR_W-1:0] rs_ex,
    output logic [REG_ADDR_W-1:0] rt_ex,
    output logic [REG_ADDR_W-1:0] rd_ex,
    output logic                  mem_read_ex,
    output logic [CTRL_W-1:0]     ctrl_ex,
    output logic                  valid_ex,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      bubble_count
);

    logic [DATA_W-1:0]     read_data_1_nxt;
    logic [DATA_W-1:0]     read_data_2_nxt;
    logic [DATA_W-1:0]     sign_extended_nxt;
    logic [REG_ADDR_W-1:0] rs_nxt;
    logic [REG_ADDR_W-1:0] rt_nxt;
    logic [REG_ADDR_W-1:0] rd_nxt;
    logic                  mem_read_nxt;
    logic [CTRL_W-1:0]     ctrl_nxt;
    logic                  valid_nxt;
    logic [CNT_W-1:0]      bubble_count_nxt;
    logic                  bubble;

    // A load in EX whose destination feeds the ID instruction; $zero never creates a dependency.
    assign hazard_stall = valid_ex & mem_read_ex & valid_id & (rt_ex != '0)
                        & ((rt_ex == rs_id) | (rt_ex == rt_id));

    always_comb begin
        read_data_1_nxt   = read_data_1_ex;
        read_data_2_nxt   = read_data_2_ex;
        sign_extended_nxt = sign_extended_ex;
        rs_nxt            = rs_ex;
        rt_nxt            = rt_ex;
        rd_nxt            = rd_ex;
        mem_read_nxt      = mem_read_ex;
        ctrl_nxt          = ctrl_ex;
        valid_nxt         = valid_ex;
        bubble_count_nxt  = bubble_count;
        bubble            = 1'b0;

        if (flush_in) begin
            bubble = 1'b1;
        end else if (stall_in) begin
            bubble = 1'b0;
        end else if (hazard_stall) begin
            bubble = 1'b1;
            if (bubble_count != '1) begin
                bubble_count_nxt = bubble_count + 1'b1;
            end
        end else begin
            read_data_1_nxt   = read_data_1_id;
            read_data_2_nxt   = read_data_2_id;
            sign_extended_nxt = sign_extended_id;
            rs_nxt            = rs_id;
            rt_nxt            = rt_id;
            rd_nxt            = rd_id;
            valid_nxt         = valid_id;
            // An empty slot must never carry live control into EX.
            mem_read_nxt      = valid_id & mem_read_id;
            ctrl_nxt          = valid_id ? ctrl_id : '0;
        end

        if (bubble) begin
            read_data_1_nxt   = '0;
            read_data_2_nxt   = '0;
            sign_extended_nxt = '0;
            rs_nxt            = '0;
            rt_nxt            = '0;
            rd_nxt            = '0;
            mem_read_nxt      = 1'b0;
            ctrl_nxt          = '0;
            valid_nxt         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data_1_ex   <= '0;
            read_data_2_ex   <= '0;
            sign_extended_ex <= '0;
            rs_ex            <= '0;
            rt_ex            <= '0;
            rd_ex            <= '0;
            mem_read_ex      <= 1'b0;
            ctrl_ex          <= '0;
            valid_ex         <= 1'b0;
            bubble_count     <= '0;
        end else begin
            read_data_1_ex   <= read_data_1_nxt;
            read_data_2_ex   <= read_data_2_nxt;
            sign_extended_ex <= sign_extended_nxt;
            rs_ex            <= rs_nxt;
            rt_ex            <= rt_nxt;
            rd_ex            <= rd_nxt;
            mem_read_ex      <= mem_read_nxt;
            ctrl_ex          <= ctrl_nxt;
            valid_ex         <= valid_nxt;
            bubble_count     <= bubble_count_nxt;
        end
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the 5-stage MIPS pipeline.
- Captures operands, the sign-extended immediate, register specifiers and control bits from ID, and presents them to EX.
- Adds a valid bit, a synchronous flush, an external hold (stall), internal load-use hazard detection with bubble insertion, and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of the operand and immediate paths
- REG_ADDR_W, 5, register specifier width
- CTRL_W, 8, width of the opaque control bundle passed ID->EX (zeroed on bubble/flush)
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- flush_in  in  1  kill ID->EX transfer (branch/jump redirect)
- stall_in  in  1  external hold; EX-side registers keep their value
- valid_id  in  1  ID stage holds a real instruction
- read_data_1_id  in  DATA_W  register file port 1 data
- read_data_2_id  in  DATA_W  register file port 2 data
- sign_extended_id  in  DATA_W  sign-extended immediate
- rs_id, rt_id, rd_id  in  REG_ADDR_W each  register specifiers
- mem_read_id  in  1  ID instruction is a load
- ctrl_id  in  CTRL_W  remaining control bits
- read_data_1_ex, read_data_2_ex, sign_extended_ex  out  DATA_W each  registered copies
- rs_ex, rt_ex, rd_ex  out  REG_ADDR_W each  registered copies
- mem_read_ex  out  1  registered load flag
- ctrl_ex  out  CTRL_W  registered control
- valid_ex  out  1  EX stage holds a real instruction
- hazard_stall  out  1  combinational; upstream must hold PC and IF/ID this cycle
- bubble_count  out  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Reset: on a clock edge with rst_n=0, every registered output goes to 0 (data, specifiers, ctrl_ex, mem_read_ex, valid_ex, bubble_count). hazard_stall=0 follows from valid_ex=0.
- Latency: 1 cycle. Values present at edge N appear on the *_ex outputs after edge N.
- hazard_stall = valid_ex & mem_read_ex & valid_id & (rt_ex != 0) & ((rt_ex == rs_id) | (rt_ex == rt_id)). Purely combinational, with no register between the inputs and this output.
- Per-edge update priority, highest first:
  1. !rst_n: reset.
  2. flush_in: bubble. valid_ex=0, ctrl_ex=0, mem_read_ex=0. Data and specifier fields are don't-care; the implementation loads them with zero. Flush wins over stall_in.
  3. stall_in: hold all EX registers unchanged, including valid_ex. The bubble counter does not change.
  4. hazard_stall: bubble as in item 2. bubble_count increments. The ID instruction is not consumed; upstream re-presents it next cycle.
  5. Otherwise: load all *_ex from *_id, with valid_ex=valid_id.
- When valid_id=0 under normal load: fields load as presented, valid_ex=0, ctrl_ex forced to 0, mem_read_ex forced to 0.
- bubble_count:
  - +1 only on hazard bubbles (item 4). Flushes are not counted.
  - Saturates at 2^CNT_W-1 and never wraps.
- A hazard persists across stall_in cycles because the EX registers hold. After a bubble, valid_ex=0, so hazard_stall deasserts on the next cycle. Each load-use pair therefore causes exactly one bubble.
- Reset asserted mid-stall or mid-hazard: reset wins. The next cycle starts from the cleared state.
- No combinational path from *_id to *_ex. The only comb outputs are hazard_stall and the ports it depends on.

Test Plan:
1. Reset then load: rst_n=0 for 2 cycles, then rst_n=1 with valid_id=1, read_data_1_id=32'h1234_5678, rd_id=5'd9, ctrl_id=8'hA5 -> after 1 edge: read_data_1_ex=32'h1234_5678, rd_ex=9, ctrl_ex=8'hA5, valid_ex=1. During reset all outputs are 0.
2. Load-use hazard: EX holds a load (mem_read_ex=1, rt_ex=5'd8, valid_ex=1), ID presents rs_id=8 -> hazard_stall=1 the same cycle. Next edge: valid_ex=0, ctrl_ex=0, bubble_count=1. Following cycle: hazard_stall=0 and the ID instruction loads normally.
3. Register-0 exclusion: same as scenario 2 but rt_ex=0, rs_id=0 -> hazard_stall=0, no bubble, bubble_count unchanged.
4. Flush versus stall: flush_in=1 and stall_in=1 together with valid_ex=1 -> next edge valid_ex=0, ctrl_ex=0. Then stall_in=1 alone for 3 cycles with new *_id values -> *_ex unchanged.
5. Stall during hazard: hazard conditions true and stall_in=1 for 2 cycles -> registers held, bubble_count unchanged, hazard_stall stays 1. Release stall -> exactly one bubble, count +1.
6. Saturation and mid-operation reset: CNT_W=2, force 5 hazard bubbles -> bubble_count stops at 3. Then pulse rst_n=0 for one edge during an active hazard -> all outputs 0, hazard_stall=0.
